// File: rtl/sd_cic_decimator.sv
// rtl/sd_cic_decimator.sv - 3rd-order CIC decimator for the two-piece sigma-delta bitstream
// Optional SDDEC_FRAME_CNT_EN adds a 16-bit output frame counter port.
module sd_cic_decimator #(
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_W      = 3 + 3 * DECIM_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sd_in,
  input  logic             in_en,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  output logic             busy
`ifdef SDDEC_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, C1, C2, C3} state_t;

  state_t state, next_state;

  logic [OUT_W-1:0] x, s1, s2, s3;
  logic [OUT_W-1:0] i1, i2, i3;
  logic [OUT_W-1:0] d0, c, z1, z2, z3;
  logic [OUT_W-1:0] sub_a, sub_b, diff;
  logic [DECIM_LOG2-1:0] cnt;
  logic tick;

  // Each piece contributes +1 for a one bit and -1 for a zero bit.
  always_comb begin
    case (sd_in)
      2'b11:   x = OUT_W'(2);
      2'b00:   x = ~OUT_W'(1);
      default: x = '0;
    endcase
  end

  assign s1   = i1 + x;
  assign s2   = i2 + s1;
  assign s3   = i3 + s2;
  assign tick = in_en & (&cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i1  <= '0;
      i2  <= '0;
      i3  <= '0;
      d0  <= '0;
      cnt <= '0;
    end else if (in_en) begin
      i1  <= s1;
      i2  <= s2;
      i3  <= s3;
      cnt <= cnt + DECIM_LOG2'(1);
      if (&cnt) d0 <= s3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // One subtractor shared by the three comb stages; operands selected by state.
  always_comb begin
    next_state = state;
    sub_a      = c;
    sub_b      = z2;
    case (state)
      IDLE: if (tick) next_state = C1;
      C1: begin
        sub_a      = d0;
        sub_b      = z1;
        next_state = C2;
      end
      C2: next_state = C3;
      C3: begin
        sub_b      = z3;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign diff = sub_a - sub_b;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c          <= '0;
      z1         <= '0;
      z2         <= '0;
      z3         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= (state == C3);
      case (state)
        C1: begin
          c  <= diff;
          z1 <= d0;
        end
        C2: begin
          c  <= diff;
          z2 <= c;
        end
        C3: begin
          dout <= diff;
          z3   <= c;
        end
        default: ;
      endcase
    end
  end

`ifdef SDDEC_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             frame_cnt <= '0;
    else if (state == C3)   frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sd_cic_decimator.sv
// tb/tb_sd_cic_decimator.sv - scoreboard bench for sd_cic_decimator against a closed-form CIC model
module tb_sd_cic_decimator;

  localparam int R     = 64;
  localparam int OUT_W = 21;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       sd_in = 2'b00;
  logic             in_en = 1'b0;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             busy;
`ifdef SDDEC_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  sd_cic_decimator dut (
    .clk        (clk),
    .reset      (reset),
    .sd_in      (sd_in),
    .in_en      (in_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
`ifdef SDDEC_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] val;
    int               at;
  } exp_t;

  exp_t   q[$];
  int     xs[$];
  longint dec[$];
  int     cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  int     busy_run = 0;
  bit     ticked;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  function automatic int xmap(logic [1:0] s);
    return (s[0] ? 1 : -1) + (s[1] ? 1 : -1);
  endfunction

  // Third integrator after sample t: x_j weighted by C(t-j+2, 2).
  function automatic longint i3_at(int t);
    longint s = 0;
    for (int j = 0; j <= t; j++) begin
      longint n = longint'(t - j + 2);
      s += (n * (n - 1) / 2) * longint'(xs[j]);
    end
    return s;
  endfunction

  function automatic longint dget(int k);
    return (k < 0) ? 0 : dec[k];
  endfunction

  // Three cascaded first differences of the decimated integrator output.
  function automatic void push_expected(int at);
    exp_t   e;
    longint y;
    int     n;
    dec.push_back(i3_at(xs.size() - 1));
    n     = dec.size();
    y     = dget(n - 1) - 3 * dget(n - 2) + 3 * dget(n - 3) - dget(n - 4);
    e.val = y[OUT_W-1:0];
    e.at  = at + 3;
    q.push_back(e);
  endfunction

  task automatic drive(input logic en, input logic [1:0] sd);
    @(negedge clk);
    in_en  = en;
    sd_in  = sd;
    ticked = 1'b0;
    if (en) begin
      xs.push_back(xmap(sd));
      if (xs.size() % R == 0) begin
        push_expected(cyc + 1);
        ticked = 1'b1;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && q.size() != 0; k++) drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    check({name, "_drained"}, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      busy_run = 0;
    end else if (dout_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("dout", dout, e.val);
        check("latency_edge", cyc, e.at);
        check("busy_cycles", busy_run, 3);
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", dout, 0);
    check("reset_valid", dout_valid, 0);
    check("reset_busy", busy, 0);
    reset = 1'b1;

    for (int i = 0; i < 6 * R; i++) drive(1'b1, 2'b11);
    drain("plus");
    check("steady_plus", dout, 21'h080000);

    for (int i = 0; i < 6 * R; i++) drive(1'b1, 2'b00);
    drain("minus");
    check("steady_minus", dout, 21'h180000);

    for (int i = 0; i < 4 * R; i++) drive(1'b1, (i % 2) ? 2'b10 : 2'b01);
    for (int i = 0; i < 3 * R; i++) drive(1'b1, 2'b01);
    drain("zero");
    check("steady_zero", dout, 0);

    for (int i = 0; i < 6 * 2 * R; i++) drive((i % 2) == 0, 2'b11);
    drain("half_rate");
    check("steady_half_rate", dout, 21'h080000);

    for (int i = 0; i < 10 * R; i++)
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
    drain("random");

    ticked = 1'b0;
    for (int k = 0; k < 4 * R && !ticked; k++) drive(1'b1, 2'($urandom_range(0, 3)));
    check("tick_reached", ticked, 1);
    @(negedge clk);
    in_en = 1'b0;
    check("busy_before_reset", busy, 1);
    reset = 1'b0;
    #1;
    check("midreset_dout", dout, 0);
    check("midreset_valid", dout_valid, 0);
    check("midreset_busy", busy, 0);
    if (ticked) void'(q.pop_back());
    xs.delete();
    dec.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3 * R; i++) drive(1'b1, 2'($urandom_range(0, 3)));
    drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_cic_decimator.md
Name: sd_cic_decimator

Overview:
- Downstream consumer of sigma_delta_twopiece_top.
- Takes the 2-bit sd_out stream (bit 0 from piece_0, bit 1 from piece_1) and maps each bit to ±1.
- Filters the result with a 3rd-order CIC and decimates by 2^DECIM_LOG2, producing a signed multi-bit sample stream for capture and analysis.
- Integrators run at the input rate. Combs run on a shared subtractor under a small FSM at the decimated rate.

Parameters:
DECIM_LOG2, 6, log2 of decimation ratio R (R = 64); legal range 2..12
OUT_W, 3+3*DECIM_LOG2, datapath/output width (21 at default); must not be overridden smaller

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
sd_in  input  2  modulator output; bit0 = piece_0, bit1 = piece_1
in_en  input  1  sample enable; sd_in accepted on rising clk when 1
dout  output  OUT_W  signed decimated sample
dout_valid  output  1  one-cycle strobe, dout valid
busy  output  1  comb FSM not in IDLE

Behaviour:
- Reset (reset=0, async assert, sync release): all integrators, comb delays, decimation counter, dout, dout_valid and busy go to 0; FSM goes to IDLE. Asserting reset mid-frame or mid-comb discards all state; there is no partial output.
- Input map: x = (sd_in[0]?+1:-1) + (sd_in[1]?+1:-1), giving x in {-2,0,+2}, sign-extended to OUT_W.
- Integrators, on an edge with in_en=1:
  - i1 <= i1+x; i2 <= i2+(i1+x); i3 <= i3+(i2+i1+x).
  - The chained-sum form is used, so i3 includes the current sample.
  - All arithmetic is two's-complement modulo 2^OUT_W; wrap-around is required and correct for CIC.
  - With in_en=0, integrators and counter hold.
- Decimation counter cnt (DECIM_LOG2 bits) increments on each accepted sample and wraps R-1 -> 0.
- Tick: the accepting edge where cnt==R-1. At this edge, d0 <= the new i3 value and the FSM goes IDLE -> C1.
- FSM, one subtraction per clock:
  - C1: c <= d0 - z1; z1 <= d0; go to C2.
  - C2: c <= c - z2; z2 <= c; go to C3.
  - C3: dout <= c - z3; z3 <= c; dout_valid <= 1; go to IDLE.
- Latency: a tick at edge E0 gives dout/dout_valid=1 registered at edge E0+3; dout_valid drops at E0+4. dout holds until the next update.
- busy=1 in C1..C3.
- Because R>=4, a new tick can never occur while busy; no stall or overflow path exists.
- The comb FSM runs regardless of in_en.
- Gain: R^3. Constant x=+2 gives steady dout = 2*R^3 = 524288 at default. The 1st and 2nd outputs after reset are transient; the 3rd and later are exact.

Optional Feature:
- Macro: SDDEC_FRAME_CNT_EN.
- Defined: adds output port frame_cnt (16 bits, unsigned).
  - Reset value 0.
  - Increments on the same edge dout_valid is set; wraps 65535 -> 0.
  - frame_cnt shown with dout_valid=1 is the 1-based count of that output.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_en=1 continuously with sd_in=2'b11 -> dout_valid pulses every 64 clocks, 3 clocks after each tick; 3rd and later dout = 524288 (0x080000); busy high exactly 3 cycles per frame.
- sd_in=2'b00 continuous -> 3rd and later dout = -524288 (0x180000 in 21 bits).
- sd_in alternating 2'b01/2'b10, or held at 2'b01 -> every dout = 0.
- in_en toggled 1,0,1,0 with sd_in=2'b11 -> ticks every 128 clocks; 3rd and later dout still 524288; integrators hold on in_en=0 cycles.
- Assert reset for 1 cycle while busy=1 (edge E0+1) -> dout, dout_valid, busy immediately 0; no dout_valid at E0+3; next output occurs 64 accepted samples after release.
- With SDDEC_FRAME_CNT_EN: run 65537 frames -> frame_cnt reads 1 on the first strobe, 65535 on strobe 65535, 0 on strobe 65536, 1 on strobe 65537.
